// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// HAZ_PERF_CNT_EN selects the optional stall/flush performance counters.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    MEM_WAIT = 2'd2,
    ERROR    = 2'd3
  } state_t;

  localparam int REG_ZERO         = 0;
  localparam int DEFAULT_MAX_WAIT = 16;

`ifdef HAZ_PERF_CNT_EN
  localparam bit PERF_CNT_EN = 1'b1;
`else
  localparam bit PERF_CNT_EN = 1'b0;
`endif

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Signal bundle between the pipeline datapath (master) and the hazard controller (slave).
// HAZ_PERF_CNT_EN adds the performance-counter outputs.
interface pipe_hazard_ctrl_if #(
  parameter int REG_ADDR_W = 5
`ifdef HAZ_PERF_CNT_EN
  , parameter int CNT_W    = 32
`endif
);
  logic                  start_i;
  logic                  id_ex_mem_read_i;
  logic [REG_ADDR_W-1:0] id_ex_rt_addr_i;
  logic [REG_ADDR_W-1:0] if_id_rs_addr_i;
  logic [REG_ADDR_W-1:0] if_id_rt_addr_i;
  logic                  if_id_uses_rt_i;
  logic                  redirect_i;
  logic                  dmem_req_i;
  logic                  dmem_ack_i;
  logic                  pc_write_o;
  logic                  if_id_write_o;
  logic                  if_id_flush_o;
  logic                  id_ex_bubble_o;
  logic                  ex_mem_write_o;
  logic                  mem_wb_write_o;
  logic [1:0]            state_o;
  logic                  err_timeout_o;
`ifdef HAZ_PERF_CNT_EN
  logic [CNT_W-1:0]      stall_cnt_o;
  logic [CNT_W-1:0]      flush_cnt_o;
`endif

  modport master (
`ifdef HAZ_PERF_CNT_EN
    input  stall_cnt_o, flush_cnt_o,
`endif
    output start_i, id_ex_mem_read_i, id_ex_rt_addr_i, if_id_rs_addr_i,
           if_id_rt_addr_i, if_id_uses_rt_i, redirect_i, dmem_req_i, dmem_ack_i,
    input  pc_write_o, if_id_write_o, if_id_flush_o, id_ex_bubble_o,
           ex_mem_write_o, mem_wb_write_o, state_o, err_timeout_o
  );

  modport slave (
`ifdef HAZ_PERF_CNT_EN
    output stall_cnt_o, flush_cnt_o,
`endif
    input  start_i, id_ex_mem_read_i, id_ex_rt_addr_i, if_id_rs_addr_i,
           if_id_rt_addr_i, if_id_uses_rt_i, redirect_i, dmem_req_i, dmem_ack_i,
    output pc_write_o, if_id_write_o, if_id_flush_o, id_ex_bubble_o,
           ex_mem_write_o, mem_wb_write_o, state_o, err_timeout_o
  );
endinterface

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Combinational load-use hazard compare between the load in ID/EX and the consumer in IF/ID.
// Kept standalone so the forwarding-unit tests can reuse it.
module hazard_detect
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic                  mem_read,
  input  logic [REG_ADDR_W-1:0] ex_rt_addr,
  input  logic [REG_ADDR_W-1:0] rs_addr,
  input  logic [REG_ADDR_W-1:0] rt_addr,
  input  logic                  uses_rt,
  output logic                  load_use
);
  // Register zero is hard-wired, so a load targeting it never creates a dependency.
  assign load_use = mem_read
                  & (ex_rt_addr != REG_ADDR_W'(REG_ZERO))
                  & ((ex_rt_addr == rs_addr) | (uses_rt & (ex_rt_addr == rt_addr)));
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Five-stage pipeline register sequencer: load-use bubbles, redirect flushes, memory freeze/timeout.
// HAZ_PERF_CNT_EN adds saturating stall and flush counters.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MAX_WAIT   = DEFAULT_MAX_WAIT,
  parameter int REG_ADDR_W = 5
`ifdef HAZ_PERF_CNT_EN
  , parameter int CNT_W    = 32
`endif
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  pipe_hazard_ctrl_if.slave  bus
);
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  state_t              state_reg, state_next;
  logic [WAIT_W-1:0]   wait_cnt_reg, wait_cnt_next;
  logic                err_reg, err_next;

  logic lu, frz, active;
  logic pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_mem_write, mem_wb_write;

  hazard_detect #(.REG_ADDR_W(REG_ADDR_W)) u_hazard_detect (
    .mem_read   (bus.id_ex_mem_read_i),
    .ex_rt_addr (bus.id_ex_rt_addr_i),
    .rs_addr    (bus.if_id_rs_addr_i),
    .rt_addr    (bus.if_id_rt_addr_i),
    .uses_rt    (bus.if_id_uses_rt_i),
    .load_use   (lu)
  );

  assign frz    = bus.dmem_req_i & ~bus.dmem_ack_i;
  assign active = (state_reg == RUN) || (state_reg == MEM_WAIT);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_reg    <= IDLE;
      wait_cnt_reg <= '0;
      err_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
      err_reg      <= err_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    wait_cnt_next = wait_cnt_reg;
    err_next      = err_reg;
    pc_write      = 1'b0;
    if_id_write   = 1'b0;
    if_id_flush   = 1'b0;
    id_ex_bubble  = 1'b1;
    ex_mem_write  = 1'b0;
    mem_wb_write  = 1'b0;

    // Enable priority: freeze > redirect > load-use > normal advance.
    if (active) begin
      if (frz) begin
        id_ex_bubble = 1'b0;
      end else if (bus.redirect_i) begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b1;
        ex_mem_write = 1'b1;
        mem_wb_write = 1'b1;
      end else if (lu) begin
        ex_mem_write = 1'b1;
        mem_wb_write = 1'b1;
      end else begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        id_ex_bubble = 1'b0;
        ex_mem_write = 1'b1;
        mem_wb_write = 1'b1;
      end
    end

    case (state_reg)
      IDLE: begin
        if (bus.start_i) state_next = RUN;
      end
      RUN: begin
        if (frz) begin
          state_next    = MEM_WAIT;
          wait_cnt_next = WAIT_W'(1);
        end
      end
      MEM_WAIT: begin
        if (bus.dmem_ack_i) begin
          state_next = RUN;
        end else if (wait_cnt_reg == WAIT_W'(MAX_WAIT)) begin
          state_next = ERROR;
          err_next   = 1'b1;
        end else begin
          wait_cnt_next = wait_cnt_reg + WAIT_W'(1);
        end
      end
      default: begin
        state_next = ERROR;
      end
    endcase
  end

  assign bus.pc_write_o     = pc_write;
  assign bus.if_id_write_o  = if_id_write;
  assign bus.if_id_flush_o  = if_id_flush;
  assign bus.id_ex_bubble_o = id_ex_bubble;
  assign bus.ex_mem_write_o = ex_mem_write;
  assign bus.mem_wb_write_o = mem_wb_write;
  assign bus.state_o        = state_reg;
  assign bus.err_timeout_o  = err_reg;

`ifdef HAZ_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_reg, flush_cnt_reg;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      stall_cnt_reg <= '0;
      flush_cnt_reg <= '0;
    end else begin
      if (active && (frz || lu) && !(&stall_cnt_reg))
        stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
      if (active && bus.redirect_i && !frz && !(&flush_cnt_reg))
        flush_cnt_reg <= flush_cnt_reg + CNT_W'(1);
    end
  end

  assign bus.stall_cnt_o = stall_cnt_reg;
  assign bus.flush_cnt_o = flush_cnt_reg;
`else
  // Counters are compiled out entirely in this build.
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed vectors push expected outputs, a negedge monitor compares.
// Build with HAZ_PERF_CNT_EN to also check the performance counters.
module tb_pipe_hazard_ctrl;
  import pipe_ctrl_pkg::*;

  localparam logic [5:0] EN_IDLE = 6'b000100;
  localparam logic [5:0] EN_RUN  = 6'b110011;
  localparam logic [5:0] EN_LU   = 6'b000111;
  localparam logic [5:0] EN_RED  = 6'b111111;
  localparam logic [5:0] EN_FRZ  = 6'b000000;

  typedef struct {
    string       nm;
    logic [1:0]  st;
    logic [5:0]  en;
    logic        err;
    bit          chk_cnt;
    logic [31:0] stall;
    logic [31:0] flush;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

`ifdef HAZ_PERF_CNT_EN
  pipe_hazard_ctrl_if #(.REG_ADDR_W(5), .CNT_W(32)) bus ();
  pipe_hazard_ctrl #(.MAX_WAIT(16), .REG_ADDR_W(5), .CNT_W(32)) dut (
`else
  pipe_hazard_ctrl_if #(.REG_ADDR_W(5)) bus ();
  pipe_hazard_ctrl #(.MAX_WAIT(16), .REG_ADDR_W(5)) dut (
`endif
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  exp_t        sb_q[$];
  int          n_vec  = 0;
  int          n_miss = 0;
  bit          done   = 1'b0;
  bit          chk_next   = 1'b0;
  logic [31:0] stall_next = '0;
  logic [31:0] flush_next = '0;

  task automatic push_exp(input string nm, input logic [1:0] st, input logic [5:0] en, input logic err);
    exp_t e;
    e.nm = nm; e.st = st; e.en = en; e.err = err;
    e.chk_cnt = chk_next; e.stall = stall_next; e.flush = flush_next;
    chk_next = 1'b0;
    sb_q.push_back(e);
  endtask

  task automatic vec(input string nm, input logic st_in, input logic mr, input logic [4:0] ex_rt,
                     input logic [4:0] rs, input logic [4:0] rt, input logic ur, input logic red,
                     input logic req, input logic ack,
                     input logic [1:0] es, input logic [5:0] een, input logic eerr);
    @(posedge clk);
    #1;
    bus.start_i          = st_in;
    bus.id_ex_mem_read_i = mr;
    bus.id_ex_rt_addr_i  = ex_rt;
    bus.if_id_rs_addr_i  = rs;
    bus.if_id_rt_addr_i  = rt;
    bus.if_id_uses_rt_i  = ur;
    bus.redirect_i       = red;
    bus.dmem_req_i       = req;
    bus.dmem_ack_i       = ack;
    push_exp(nm, es, een, eerr);
  endtask

  // Monitor: owns all comparison counters and prints the summary.
  initial begin : monitor
    exp_t e;
    logic [5:0] got_en;
    int cyc = 0;
    while (!done && cyc < 5000) begin
      @(negedge clk);
      cyc++;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        got_en = {bus.pc_write_o, bus.if_id_write_o, bus.if_id_flush_o,
                  bus.id_ex_bubble_o, bus.ex_mem_write_o, bus.mem_wb_write_o};
        n_vec++;
        if (bus.state_o !== e.st || got_en !== e.en || bus.err_timeout_o !== e.err) begin
          n_miss++;
          $display("FAIL %s: got state=%0d en=%b err=%b, expected state=%0d en=%b err=%b",
                   e.nm, bus.state_o, got_en, bus.err_timeout_o, e.st, e.en, e.err);
        end else begin
          $display("ok   %s: state=%0d en=%b err=%b", e.nm, bus.state_o, got_en, bus.err_timeout_o);
        end
`ifdef HAZ_PERF_CNT_EN
        if (e.chk_cnt) begin
          n_vec++;
          if (bus.stall_cnt_o !== e.stall || bus.flush_cnt_o !== e.flush) begin
            n_miss++;
            $display("FAIL %s_cnt: got stall=%0d flush=%0d, expected stall=%0d flush=%0d",
                     e.nm, bus.stall_cnt_o, bus.flush_cnt_o, e.stall, e.flush);
          end else begin
            $display("ok   %s_cnt: stall=%0d flush=%0d", e.nm, bus.stall_cnt_o, bus.flush_cnt_o);
          end
        end
`endif
      end
    end
    if (!done) begin
      n_miss++;
      $display("FAIL timeout: got stimulus still running after %0d cycles, expected completion", cyc);
    end
    if (sb_q.size() != 0) begin
      n_miss++;
      $display("FAIL drain: got %0d unchecked vectors, expected 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin : stimulus
    bus.start_i = 0; bus.id_ex_mem_read_i = 0; bus.id_ex_rt_addr_i = 0;
    bus.if_id_rs_addr_i = 0; bus.if_id_rt_addr_i = 0; bus.if_id_uses_rt_i = 0;
    bus.redirect_i = 0; bus.dmem_req_i = 0; bus.dmem_ack_i = 0;

    chk_next = 1; stall_next = 0; flush_next = 0;
    vec("reset",        0,0,0,0,0,0,0,0,0, 2'd0, EN_IDLE, 0);
    @(posedge clk); #1 rst_n = 1'b1;

    //  name            st mr rt rs rt2 ur red req ack  state  enables  err
    vec("idle_start",    1,0, 0, 0, 0, 0, 0, 0, 0,   2'd0, EN_IDLE, 0);
    vec("run",           0,0, 0, 0, 0, 0, 0, 0, 0,   2'd1, EN_RUN,  0);
    vec("lu_rs",         0,1, 5, 5, 0, 0, 0, 0, 0,   2'd1, EN_LU,   0);
    vec("lu_clear",      0,0, 5, 5, 0, 0, 0, 0, 0,   2'd1, EN_RUN,  0);
    vec("lu_rt",         0,1, 7, 1, 7, 1, 0, 0, 0,   2'd1, EN_LU,   0);
    vec("lu_rt_unused",  0,1, 7, 1, 7, 0, 0, 0, 0,   2'd1, EN_RUN,  0);
    vec("lu_zero",       0,1, 0, 0, 0, 1, 0, 0, 0,   2'd1, EN_RUN,  0);
    vec("redir_lu",      0,1, 5, 5, 0, 0, 1, 0, 0,   2'd1, EN_RED,  0);
    vec("start_ignored", 1,0, 0, 0, 0, 0, 0, 0, 0,   2'd1, EN_RUN,  0);
    vec("frz_enter",     0,0, 0, 0, 0, 0, 0, 1, 0,   2'd1, EN_FRZ,  0);
    vec("frz_wait1",     0,0, 0, 0, 0, 0, 0, 1, 0,   2'd2, EN_FRZ,  0);
    vec("frz_wait2",     0,0, 0, 0, 0, 0, 0, 1, 0,   2'd2, EN_FRZ,  0);
    vec("ack",           0,0, 0, 0, 0, 0, 0, 1, 1,   2'd2, EN_RUN,  0);
    vec("after_ack",     0,0, 0, 0, 0, 0, 0, 0, 0,   2'd1, EN_RUN,  0);
    vec("zero_wait",     0,0, 0, 0, 0, 0, 0, 1, 1,   2'd1, EN_RUN,  0);
    vec("no_mem_wait",   0,0, 0, 0, 0, 0, 0, 0, 0,   2'd1, EN_RUN,  0);
    vec("frz_enter2",    0,0, 0, 0, 0, 0, 0, 1, 0,   2'd1, EN_FRZ,  0);
    vec("ack_lu",        0,1, 9, 9, 0, 0, 0, 1, 1,   2'd2, EN_LU,   0);
    vec("frz_enter3",    0,0, 0, 0, 0, 0, 0, 1, 0,   2'd1, EN_FRZ,  0);
    vec("ack_redirect",  0,0, 0, 0, 0, 0, 1, 1, 1,   2'd2, EN_RED,  0);
    vec("frz_over_red",  0,1, 5, 5, 0, 0, 1, 1, 0,   2'd1, EN_FRZ,  0);
    for (int i = 1; i <= 16; i++)
      vec($sformatf("timeout_wait%0d", i), 0,0,0,0,0,0,0,1,0, 2'd2, EN_FRZ, 0);
    vec("timeout_err",   0,0, 0, 0, 0, 0, 0, 1, 0,   2'd3, EN_IDLE, 1);
    vec("err_start",     1,0, 0, 0, 0, 0, 0, 0, 0,   2'd3, EN_IDLE, 1);
    vec("err_hold",      0,0, 0, 0, 0, 0, 0, 0, 0,   2'd3, EN_IDLE, 1);

    // Mid-cycle reset must take effect before the next edge.
    @(posedge clk); #1 rst_n = 1'b0;
    chk_next = 1; stall_next = 0; flush_next = 0;
    push_exp("reset_mid", 2'd0, EN_IDLE, 0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Counter scenario: 2 load-use stalls, 1 redirect, 3 frozen cycles.
    vec("p_start",       1,0, 0, 0, 0, 0, 0, 0, 0,   2'd0, EN_IDLE, 0);
    vec("p_run",         0,0, 0, 0, 0, 0, 0, 0, 0,   2'd1, EN_RUN,  0);
    vec("p_lu1",         0,1, 5, 5, 0, 0, 0, 0, 0,   2'd1, EN_LU,   0);
    vec("p_lu2",         0,1, 6, 2, 6, 1, 0, 0, 0,   2'd1, EN_LU,   0);
    vec("p_redirect",    0,0, 0, 0, 0, 0, 1, 0, 0,   2'd1, EN_RED,  0);
    vec("p_frz",         0,0, 0, 0, 0, 0, 0, 1, 0,   2'd1, EN_FRZ,  0);
    vec("p_wait1",       0,0, 0, 0, 0, 0, 0, 1, 0,   2'd2, EN_FRZ,  0);
    vec("p_wait2",       0,0, 0, 0, 0, 0, 0, 1, 0,   2'd2, EN_FRZ,  0);
    vec("p_ack",         0,0, 0, 0, 0, 0, 0, 1, 1,   2'd2, EN_RUN,  0);
    chk_next = 1; stall_next = 5; flush_next = 1;
    vec("p_counts",      0,0, 0, 0, 0, 0, 0, 0, 0,   2'd1, EN_RUN,  0);

    repeat (2) @(posedge clk);
    done = 1'b1;
  end

endmodule
